// File: rtl/flick_debouncer.sv
// rtl/flick_debouncer.sv - synchroniser and bounce filter for the flick button with rise/fall pulses
// Optional FLICK_GLITCH_CNT_EN adds an 8-bit saturating count of aborted checks on glitch_count.
module flick_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flick_raw,
    output logic       flick,
    output logic       flick_rise,
`ifdef FLICK_GLITCH_CNT_EN
    output logic       flick_fall,
    output logic [7:0] glitch_count
`else
    output logic       flick_fall
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW_STABLE,
        CHECK_HIGH,
        HIGH_STABLE,
        CHECK_LOW
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flick_q, flick_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], flick_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            flick_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flick_q <= flick_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW_STABLE: begin
                if (s) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!s) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so pulses line up with the flick edge.
        flick_d = (state_d == HIGH_STABLE) || (state_d == CHECK_LOW);
    end

    assign flick      = flick_q;
    assign flick_rise = rise_q;
    assign flick_fall = fall_q;

`ifdef FLICK_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q, glitch_d;

    assign abort    = ((state_q == CHECK_HIGH) && !s) || ((state_q == CHECK_LOW) && s);
    assign glitch_d = (abort && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_flick_debouncer.sv
// tb/tb_flick_debouncer.sv - directed bench for flick_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
module tb_flick_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic flick_raw;
    logic flick;
    logic flick_rise;
    logic flick_fall;
`ifdef FLICK_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int pulse_viol = 0;
    logic prev_flick = 1'b0;
    logic prev_pulse = 1'b0;
    int r0, f0, g0;
    logic bounce_pat [0:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    flick_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flick_raw   (flick_raw),
        .flick       (flick),
        .flick_rise  (flick_rise),
`ifdef FLICK_GLITCH_CNT_EN
        .flick_fall  (flick_fall),
        .glitch_count(glitch_count)
`else
        .flick_fall  (flick_fall)
`endif
    );

    // Pulse bookkeeping: exclusivity, no back-to-back pulses, pulses coincide with flick edges.
    always @(negedge clk) begin
        if (!rst) begin
            rise_cnt <= rise_cnt + int'(flick_rise);
            fall_cnt <= fall_cnt + int'(flick_fall);
            if ((flick_rise && flick_fall) || ((flick_rise || flick_fall) && prev_pulse) ||
                (flick_rise != (flick && !prev_flick)) || (flick_fall != (!flick && prev_flick)))
                pulse_viol <= pulse_viol + 1;
        end
        prev_flick <= flick;
        prev_pulse <= flick_rise || flick_fall;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst       = 1'b1;
        flick_raw = 1'b1;
        ticks(3);
        chk("rst_flick", flick, 0);
        chk("rst_rise", flick_rise, 0);
        chk("rst_fall", flick_fall, 0);
`ifdef FLICK_GLITCH_CNT_EN
        chk("rst_glitch", glitch_count, 0);
`endif

        rst = 1'b0;
        r0  = rise_cnt;
        ticks(6);
        chk("rise_not_early", flick, 0);
        tick();
        chk("rise_flick", flick, 1);
        chk("rise_pulse", flick_rise, 1);
        tick();
        chk("rise_pulse_one", flick_rise, 0);
        chk("rise_hold", flick, 1);
        chk("rise_count", rise_cnt - r0, 1);

        r0 = rise_cnt;
        f0 = fall_cnt;
        flick_raw = 1'b0;
        ticks(6);
        chk("fall_not_early", flick, 1);
        tick();
        chk("fall_flick", flick, 0);
        chk("fall_pulse", flick_fall, 1);
        tick();
        chk("fall_pulse_one", flick_fall, 0);
        chk("fall_count", fall_cnt - f0, 1);
        chk("fall_no_rise", rise_cnt - r0, 0);

`ifdef FLICK_GLITCH_CNT_EN
        g0 = int'(glitch_count);
`else
        g0 = 0;
`endif
        r0 = rise_cnt;
        flick_raw = 1'b1;
        ticks(3);
        flick_raw = 1'b0;
        ticks(10);
        chk("short_flick", flick, 0);
        chk("short_no_rise", rise_cnt - r0, 0);
`ifdef FLICK_GLITCH_CNT_EN
        chk("short_glitch", int'(glitch_count) - g0, 1);
        g0 = int'(glitch_count);
`endif

        r0 = rise_cnt;
        for (int i = 0; i < 9; i++) begin
            flick_raw = bounce_pat[i];
            tick();
        end
        flick_raw = 1'b1;
        ticks(2);
        chk("bounce_not_early", flick, 0);
        tick();
        chk("bounce_flick", flick, 1);
        chk("bounce_pulse", flick_rise, 1);
        tick();
        chk("bounce_one_rise", rise_cnt - r0, 1);
`ifdef FLICK_GLITCH_CNT_EN
        chk("bounce_glitch", int'(glitch_count) - g0, 2);
`endif

        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_flick", flick, 0);
        f0 = fall_cnt;
        r0 = rise_cnt;
        ticks(2);
        rst = 1'b0;
        ticks(6);
        chk("rerise_not_early", flick, 0);
        tick();
        chk("rerise_pulse", flick_rise, 1);
        tick();
        chk("rst_no_fall", fall_cnt - f0, 0);
        chk("rerise_count", rise_cnt - r0, 1);

        flick_raw = 1'b0;
        ticks(10);
        flick_raw = 1'b1;
        ticks(5);
        rst = 1'b1;
        #1;
        chk("midchk_flick", flick, 0);
        chk("midchk_rise", flick_rise, 0);
        r0 = rise_cnt;
        tick();
        rst = 1'b0;
        ticks(6);
        chk("midchk_not_early", flick, 0);
        tick();
        chk("midchk_flick_up", flick, 1);
        chk("midchk_pulse", flick_rise, 1);
        tick();
        chk("midchk_one_rise", rise_cnt - r0, 1);
`ifdef FLICK_GLITCH_CNT_EN
        chk("midchk_glitch_clr", glitch_count, 0);
`endif

        flick_raw = 1'b0;
        ticks(10);
        r0 = rise_cnt;
        f0 = fall_cnt;
        for (int i = 0; i < 300; i++) begin
            flick_raw = 1'b1;
            ticks(2);
            flick_raw = 1'b0;
            ticks(2);
        end
        ticks(5);
        chk("sat_flick", flick, 0);
        chk("sat_no_rise", rise_cnt - r0, 0);
        chk("sat_no_fall", fall_cnt - f0, 0);
`ifdef FLICK_GLITCH_CNT_EN
        chk("sat_glitch", glitch_count, 255);
`endif

        chk("pulse_rules", pulse_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
